// File: rtl/incrementor_seq.sv
`default_nettype none
// ============================================================================
// Module   : incrementor_seq
// Brief    : Multi-cycle incrementor that adds N to A one step per enabled clock.
// Revision : 1.0
// ============================================================================
module incrementor_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Ia,
    output logic             C
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_ia_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_rem_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ia_q, ia_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               c_q, c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        ia_d    = ia_q;
        rem_d   = rem_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (E && start) begin
                    ia_d    = A;
                    rem_d   = N;
                    c_d     = 1'b0;
                    state_d = (N == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (E) begin
                    ia_d  = ia_q + c_ia_one;
                    rem_d = rem_q - c_rem_one;
                    // Wrap is detected on the pre-step value and stays sticky.
                    if (ia_q == '1) begin
                        c_d = 1'b1;
                    end
                    if (rem_q == c_rem_one) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ia_q    <= '0;
            rem_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
            rem_q   <= rem_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Ia   = ia_q;
    assign C    = c_q;

endmodule
`default_nettype wire
